// File: rtl/output_bus_driver.sv
// output_bus_driver: board-side consumer of the 47-bit routine OutputBus.
// Captures routine frames into a shadow register and swaps them into the
// display register only at scan-frame boundaries, so a frame never tears.
// Time-multiplexes the four active-low digit fields onto one segment bus,
// PWM-dims the 18 LEDs and forwards the aux bit.
// Optional feature macro: OUTPUT_BUS_DRIVER_HEX_DECODE_EN adds DigitHex and
// HexValid, a reverse decode of each displayed digit against the hex font.
module output_bus_driver #(
  parameter int SCAN_DIV = 1000,
  parameter int BLANK    = 2,
  parameter int PWM_BITS = 4
) (
  input  logic                Clock,
  input  logic                Reset,
  input  logic [46:0]         BusIn,
  input  logic                BusValid,
  input  logic [PWM_BITS-1:0] Brightness,
  output logic [6:0]          SegOut,
  output logic [3:0]          DigitEn,
  output logic [17:0]         LedOut,
  output logic                AuxOut,
  output logic                FrameTick
`ifdef OUTPUT_BUS_DRIVER_HEX_DECODE_EN
  ,
  output logic [15:0]         DigitHex,
  output logic [3:0]          HexValid
`endif
);

  localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [SW-1:0] SLOT_LAST = SW'(SCAN_DIV - 1);
  localparam logic [SW-1:0] BLANK_CNT = SW'(BLANK);
  localparam logic [46:0]   BLANK_FRAME = {1'b0, 18'd0, {4{7'h7F}}};

  logic [46:0]         shadow_q, shadow_d;
  logic [46:0]         display_q, display_d;
  logic                pending_q, pending_d;
  logic                loaded_q, loaded_d;
  logic [SW-1:0]       slotCnt_q, slotCnt_d;
  logic [1:0]          digitIdx_q, digitIdx_d;
  logic [PWM_BITS-1:0] pwmCnt_q, pwmCnt_d;
  logic [6:0]          segOut_q, segOut_d;
  logic [3:0]          digitEn_q, digitEn_d;
  logic [17:0]         ledOut_q, ledOut_d;
  logic                auxOut_q, auxOut_d;
  logic                frameTick_q, frameTick_d;
  logic                boundary;
  logic [6:0]          digitField;

  assign boundary = (slotCnt_q == SLOT_LAST) && (digitIdx_q == 2'd3);

  // Scan counters, PWM counter, and shadow/display frame hand-over
  always_comb begin
    slotCnt_d  = slotCnt_q + 1'b1;
    digitIdx_d = digitIdx_q;
    if (slotCnt_q == SLOT_LAST) begin
      slotCnt_d  = '0;
      digitIdx_d = digitIdx_q + 2'd1;
    end
    pwmCnt_d  = pwmCnt_q + 1'b1;
    shadow_d  = BusValid ? BusIn : shadow_q;
    pending_d = pending_q;
    display_d = display_q;
    loaded_d  = loaded_q;
    if (boundary && pending_q) begin
      display_d = shadow_q;
      loaded_d  = 1'b1;
      pending_d = 1'b0;
    end
    if (BusValid) begin
      pending_d = 1'b1;
    end
  end

  // Output stage: digit select with anti-ghost blanking, LED PWM gate, aux, frame tick
  always_comb begin
    case (digitIdx_q)
      2'd0:    digitField = display_q[6:0];
      2'd1:    digitField = display_q[13:7];
      2'd2:    digitField = display_q[20:14];
      default: digitField = display_q[27:21];
    endcase
    segOut_d  = 7'h7F;
    digitEn_d = 4'hF;
    // Digit enables stay off until a real frame has been shown at least once
    if (loaded_q && (slotCnt_q >= BLANK_CNT)) begin
      segOut_d  = digitField;
      digitEn_d = ~(4'b0001 << digitIdx_q);
    end
    ledOut_d = '0;
    if ((Brightness == '1) || (Brightness > pwmCnt_q)) begin
      ledOut_d = display_q[45:28];
    end
    auxOut_d    = display_q[46];
    frameTick_d = boundary;
  end

  // State and registered outputs with synchronous active-low reset
  always_ff @(posedge Clock) begin
    if (!Reset) begin
      shadow_q    <= BLANK_FRAME;
      display_q   <= BLANK_FRAME;
      pending_q   <= 1'b0;
      loaded_q    <= 1'b0;
      slotCnt_q   <= '0;
      digitIdx_q  <= 2'd0;
      pwmCnt_q    <= '0;
      segOut_q    <= 7'h7F;
      digitEn_q   <= 4'hF;
      ledOut_q    <= '0;
      auxOut_q    <= 1'b0;
      frameTick_q <= 1'b0;
    end else begin
      shadow_q    <= shadow_d;
      display_q   <= display_d;
      pending_q   <= pending_d;
      loaded_q    <= loaded_d;
      slotCnt_q   <= slotCnt_d;
      digitIdx_q  <= digitIdx_d;
      pwmCnt_q    <= pwmCnt_d;
      segOut_q    <= segOut_d;
      digitEn_q   <= digitEn_d;
      ledOut_q    <= ledOut_d;
      auxOut_q    <= auxOut_d;
      frameTick_q <= frameTick_d;
    end
  end

  assign SegOut    = segOut_q;
  assign DigitEn   = digitEn_q;
  assign LedOut    = ledOut_q;
  assign AuxOut    = auxOut_q;
  assign FrameTick = frameTick_q;

`ifdef OUTPUT_BUS_DRIVER_HEX_DECODE_EN
  logic [15:0] digitHex_q, digitHex_d;
  logic [3:0]  hexValid_q, hexValid_d;
  logic [4:0]  decoded;

  // Returns {valid, nibble} for an active-high GFEDCBA pattern
  function automatic logic [4:0] hexDecode(input logic [6:0] segs);
    case (segs)
      7'h3F:   hexDecode = {1'b1, 4'h0};
      7'h06:   hexDecode = {1'b1, 4'h1};
      7'h5B:   hexDecode = {1'b1, 4'h2};
      7'h4F:   hexDecode = {1'b1, 4'h3};
      7'h66:   hexDecode = {1'b1, 4'h4};
      7'h6D:   hexDecode = {1'b1, 4'h5};
      7'h7D:   hexDecode = {1'b1, 4'h6};
      7'h07:   hexDecode = {1'b1, 4'h7};
      7'h7F:   hexDecode = {1'b1, 4'h8};
      7'h6F:   hexDecode = {1'b1, 4'h9};
      7'h77:   hexDecode = {1'b1, 4'hA};
      7'h7C:   hexDecode = {1'b1, 4'hB};
      7'h39:   hexDecode = {1'b1, 4'hC};
      7'h5E:   hexDecode = {1'b1, 4'hD};
      7'h79:   hexDecode = {1'b1, 4'hE};
      7'h71:   hexDecode = {1'b1, 4'hF};
      default: hexDecode = 5'b0_0000;
    endcase
  endfunction

  // Reverse-decode each displayed digit field (inverted to active-high first)
  always_comb begin
    digitHex_d = '0;
    hexValid_d = '0;
    decoded    = '0;
    for (int n = 0; n < 4; n++) begin
      decoded             = hexDecode(~display_q[7*n +: 7]);
      digitHex_d[4*n +: 4] = decoded[3:0];
      hexValid_d[n]        = decoded[4];
    end
  end

  // Registered hex outputs, cleared by reset
  always_ff @(posedge Clock) begin
    if (!Reset) begin
      digitHex_q <= '0;
      hexValid_q <= '0;
    end else begin
      digitHex_q <= digitHex_d;
      hexValid_q <= hexValid_d;
    end
  end

  assign DigitHex = digitHex_q;
  assign HexValid = hexValid_q;
`endif

endmodule
